display_scan_mux: RTL and testbench

- Time-multiplexes four BCD time digits (HH:MM) onto a single 4-bit digit bus that feeds seven_seg_decoder.
- Drives the common-anode enables and the decimal point.
- Sits between the timekeeping counters and the decoder.
- Provides a tear-free snapshot, per-digit blink for set mode, leading-zero blanking and a PM indicator.

---
 rtl/clock_disp_pkg.sv | 21 ++
 rtl/display_scan_mux_tick_div.sv | 26 ++
 rtl/display_scan_mux.sv | 99 +++++++++
 tb/tb_display_scan_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path: blank codes, anode patterns
// and digit slot indices used by the scan multiplexer.
package clock_disp_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam int         GHOST_CYC  = 16;

    typedef enum logic [1:0] {
        DIG_MIN_ONES = 2'd0,
        DIG_MIN_TENS = 2'd1,
        DIG_HR_ONES  = 2'd2,
        DIG_HR_TENS  = 2'd3
    } digit_idx_e;

    // Active-low one-hot anode pattern for a lit digit slot.
    function automatic logic [3:0] anOneHot(input digit_idx_e idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_mux_tick_div.sv
// Free-running modulo-DIV counter with a single-cycle tick on the last count.
module tick_div #(
    parameter int DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [$clog2(DIV)-1:0]  cnt_o,
    output logic                    tick_o
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit HH:MM scan multiplexer with frame snapshot, blink, leading-zero
// blanking and PM dot. Define DISPLAY_SCAN_GHOST_BLANK_EN for per-slot dead time.
module display_scan_mux
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hr_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] blink_mask,
    input  logic       lz_blank,
    input  logic       pm,
    output logic [3:0] digit_bcd,
    output logic [3:0] an,
    output logic       dp
);
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int BCW = $clog2(BLINK_DIV);
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif

    logic [SCW-1:0]  scanCnt;
    logic            scanTick;
    logic [BCW-1:0]  unusedBlinkCnt;
    logic            blinkTick;

    digit_idx_e      idx_q, idx_d;
    logic            blinkPhase_q;
    logic            init_q;
    logic [3:0][3:0] snapDig_q;
    logic            snapPm_q;

    logic            capture;
    logic            blank;
    logic [3:0]      digNext;
    logic [3:0]      anNext;
    logic            dpNext;

    tick_div #(.DIV(SCAN_DIV)) uScanDiv (
        .clk    (clk),
        .rst    (rst),
        .cnt_o  (scanCnt),
        .tick_o (scanTick)
    );

    tick_div #(.DIV(BLINK_DIV)) uBlinkDiv (
        .clk    (clk),
        .rst    (rst),
        .cnt_o  (unusedBlinkCnt),
        .tick_o (blinkTick)
    );

    // Snapshot only at frame boundaries so one frame never mixes old and new time.
    always_comb begin
        idx_d   = scanTick ? digit_idx_e'(idx_q + 2'd1) : idx_q;
        capture = init_q | (scanTick & (idx_q == DIG_HR_TENS));

        blank = (blink_mask[idx_q] & blinkPhase_q)
              | ((idx_q == DIG_HR_TENS) & lz_blank & (snapDig_q[DIG_HR_TENS] == 4'd0))
              | (GHOST_EN & (scanCnt < SCW'(GHOST_CYC)));

        digNext = blank ? BLANK_CODE : snapDig_q[idx_q];
        anNext  = blank ? AN_OFF     : anOneHot(idx_q);
        dpNext  = !((idx_q == DIG_MIN_ONES) & snapPm_q & !blank);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= DIG_MIN_ONES;
            blinkPhase_q <= 1'b0;
            init_q       <= 1'b1;
            snapDig_q    <= {4{BLANK_CODE}};
            snapPm_q     <= 1'b0;
            digit_bcd    <= BLANK_CODE;
            an           <= AN_OFF;
            dp           <= 1'b1;
        end else begin
            idx_q        <= idx_d;
            blinkPhase_q <= blinkPhase_q ^ blinkTick;
            init_q       <= 1'b0;
            if (capture) begin
                snapDig_q <= {hr_tens, hr_ones, min_tens, min_ones};
                snapPm_q  <= pm;
            end
            digit_bcd    <= digNext;
            an           <= anNext;
            dp           <= dpNext;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: stimulus queues hand-computed
// expectations keyed by cycle, a monitor compares them on the falling edge.
module tb_display_scan_mux;

    localparam int SCAN_DIV  = 32;
    localparam int BLINK_DIV = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hr_tens = 4'd1;
    logic [3:0] hr_ones = 4'd2;
    logic [3:0] min_tens = 4'd3;
    logic [3:0] min_ones = 4'd4;
    logic [3:0] blink_mask = 4'b0000;
    logic       lz_blank = 1'b0;
    logic       pm = 1'b0;
    logic [3:0] digit_bcd;
    logic [3:0] an;
    logic       dp;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dp;
        string      name;
    } expect_t;

    expect_t expQ[$];
    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;

    display_scan_mux #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .hr_tens    (hr_tens),
        .hr_ones    (hr_ones),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .pm         (pm),
        .digit_bcd  (digit_bcd),
        .an         (an),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: value n means n active edges have passed.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Output at cycle n reflects slot state of cycle n-1; the dead-time build
    // blanks the first GHOST_CYC counts of every slot.
    task automatic applyStimulus(input int c, input logic [3:0] eAn,
                                 input logic [3:0] eBcd, input logic eDp,
                                 input string name);
        expect_t e;
        e.cyc  = c;
        e.an   = eAn;
        e.bcd  = eBcd;
        e.dp   = eDp;
        e.name = name;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
        if (c > 0 && ((c - 1) % SCAN_DIV) < 16) begin
            e.an  = 4'b1111;
            e.bcd = 4'hF;
            e.dp  = 1'b1;
        end
`endif
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if (an !== e.an || digit_bcd !== e.bcd || dp !== e.dp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got an=%b bcd=%h dp=%b want an=%b bcd=%h dp=%b",
                     e.name, cyc, an, digit_bcd, dp, e.an, e.bcd, e.dp);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            if (expQ[0].cyc == cyc) begin
                checkOutput(expQ.pop_front());
            end else if (expQ[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s missed at cyc=%0d want cyc=%0d",
                         expQ[0].name, cyc, expQ[0].cyc);
                void'(expQ.pop_front());
            end
        end
    end

    task automatic waitCyc(input int n);
        int budget;
        budget = 5000;
        while (cyc < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            failures++;
            $display("[TB] FAIL wait_cyc_%0d timeout at cyc=%0d", n, cyc);
        end
    endtask

    initial begin
        applyStimulus(0,    4'b1111, 4'hF, 1'b1, "reset_state");
        applyStimulus(1,    4'b1110, 4'hF, 1'b1, "init_blank_snap");
        applyStimulus(2,    4'b1110, 4'h4, 1'b1, "first_digit");
        applyStimulus(16,   4'b1110, 4'h4, 1'b1, "slot0_c16");
        applyStimulus(17,   4'b1110, 4'h4, 1'b1, "slot0_c17");
        applyStimulus(32,   4'b1110, 4'h4, 1'b1, "slot0_end");
        applyStimulus(33,   4'b1101, 4'h3, 1'b1, "slot1_start");
        applyStimulus(50,   4'b1101, 4'h3, 1'b1, "slot1_mid");
        applyStimulus(65,   4'b1011, 4'h2, 1'b1, "slot2_start");
        applyStimulus(80,   4'b1011, 4'h2, 1'b1, "slot2_mid");
        applyStimulus(97,   4'b0111, 4'h1, 1'b1, "slot3_start");
        applyStimulus(110,  4'b0111, 4'h1, 1'b1, "slot3_mid");
        applyStimulus(129,  4'b1110, 4'h4, 1'b1, "wrap_slot0");
        applyStimulus(150,  4'b1110, 4'h4, 1'b1, "frame1_slot0");
        applyStimulus(160,  4'b1110, 4'h4, 1'b1, "frame1_slot0_end");
        applyStimulus(257,  4'b1110, 4'h5, 1'b1, "snap_new_start");
        applyStimulus(277,  4'b1110, 4'h5, 1'b1, "snap_new_mid");
        applyStimulus(370,  4'b0111, 4'h1, 1'b1, "lz_before_snap");
        applyStimulus(385,  4'b1110, 4'h5, 1'b1, "frame3_slot0");
        applyStimulus(490,  4'b1111, 4'hF, 1'b1, "lz_blank_on");
        applyStimulus(512,  4'b1111, 4'hF, 1'b1, "lz_blank_end");
        applyStimulus(620,  4'b0111, 4'h0, 1'b1, "lz_blank_off");
        applyStimulus(790,  4'b1110, 4'h5, 1'b1, "blink_other0");
        applyStimulus(820,  4'b1101, 4'h3, 1'b1, "blink_other1");
        applyStimulus(850,  4'b1011, 4'h2, 1'b1, "blink_other2");
        applyStimulus(880,  4'b1111, 4'hF, 1'b1, "blink_hr_tens");
        applyStimulus(910,  4'b1110, 4'h5, 1'b1, "pm_not_snapped");
        applyStimulus(1040, 4'b1110, 4'h5, 1'b0, "pm_dot_on");
        applyStimulus(1070, 4'b1101, 4'h3, 1'b1, "pm_dot_slot1");
        applyStimulus(1090, 4'b1111, 4'hF, 1'b1, "blink_phase1_slot2");
        applyStimulus(1095, 4'b1111, 4'hF, 1'b1, "blink_phase1_slot2b");

        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        waitCyc(170);
        min_ones = 4'd5;
        waitCyc(260);
        hr_tens  = 4'd0;
        lz_blank = 1'b1;
        waitCyc(520);
        lz_blank = 1'b0;
        waitCyc(650);
        hr_tens  = 4'd1;
        waitCyc(700);
        blink_mask = 4'b1000;
        waitCyc(900);
        blink_mask = 4'b1111;
        pm         = 1'b1;
        waitCyc(1096);
        hr_tens    = 4'd9;
        hr_ones    = 4'd8;
        min_tens   = 4'd7;
        min_ones   = 4'd6;
        blink_mask = 4'b0000;
        pm         = 1'b0;
        waitCyc(1100);

        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(0,   4'b1111, 4'hF, 1'b1, "async_reset");
        applyStimulus(1,   4'b1110, 4'hF, 1'b1, "rst2_init");
        applyStimulus(2,   4'b1110, 4'h6, 1'b1, "rst2_first");
        applyStimulus(20,  4'b1110, 4'h6, 1'b1, "rst2_slot0");
        applyStimulus(40,  4'b1101, 4'h7, 1'b1, "rst2_slot1");
        applyStimulus(80,  4'b1011, 4'h8, 1'b1, "rst2_slot2");
        applyStimulus(110, 4'b0111, 4'h9, 1'b1, "rst2_slot3");
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        begin
            int budget;
            budget = 1000;
            while (expQ.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (expQ.size() > 0) begin
                failures++;
                $display("[TB] FAIL drain_timeout pending=%0d", expQ.size());
            end
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
